// File: rtl/rv_fetch_aligner_if.sv
// rv_fetch_aligner_if: fetch-word and instruction handshakes of the fetch aligner
interface rv_fetch_aligner_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    modport master (
        input  fetch_valid, fetch_addr, fetch_data, fetch_error, inst_ready,
        output fetch_ready, inst_valid, inst, inst_pc, inst_fault
    );
    modport slave (
        output fetch_valid, fetch_addr, fetch_data, fetch_error, inst_ready,
        input  fetch_ready, inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/rv_fetch_aligner.sv
// rv_fetch_aligner: halfword buffer turning aligned fetch words into 16/32-bit instructions
module rv_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    rv_fetch_aligner_if.master   bus
);
    logic [15:0] hw [3];
    logic [15:0] hw_n [3];
    logic [2:0]  hf, hf_n;
    logic [1:0]  count, cnt_p, count_n;
    logic [31:0] head_pc;
    logic [29:0] exp_addr;
    logic        skip, is16, pop, stale, accept;

    assign is16           = hw[0][1:0] != 2'b11 || hf[0];
    assign bus.inst_valid = !flush && count != 2'd0 && (is16 || count[1]);
    assign bus.inst       = is16 ? {16'h0000, hw[0]} : {hw[1], hw[0]};
    assign bus.inst_pc    = head_pc;
    assign bus.inst_fault = hf[0] || (!is16 && hf[1]);
    assign stale          = bus.fetch_valid && bus.fetch_addr[31:2] != exp_addr;
    assign bus.fetch_ready = reset_n && !flush && (stale || !count[1]);
    assign pop            = bus.inst_valid && bus.inst_ready;
    assign accept         = bus.fetch_valid && !stale && bus.fetch_ready;
    assign cnt_p          = count - (pop ? (is16 ? 2'd1 : 2'd2) : 2'd0);
    assign count_n        = cnt_p + (accept ? (skip ? 2'd1 : 2'd2) : 2'd0);

    // pop shifts the buffer down, then the new word lands at the post-pop tail
    always_comb begin
        hw_n[0] = pop ? (is16 ? hw[1] : hw[2]) : hw[0];
        hw_n[1] = pop ? hw[2] : hw[1];
        hw_n[2] = hw[2];
        hf_n    = pop ? (is16 ? {hf[2], hf[2:1]} : {hf[2], hf[2], hf[2]}) : hf;
        if (accept) begin
            hw_n[cnt_p] = skip ? bus.fetch_data[31:16] : bus.fetch_data[15:0];
            hf_n[cnt_p] = bus.fetch_error;
            if (!skip) begin
                hw_n[cnt_p + 2'd1] = bus.fetch_data[31:16];
                hf_n[cnt_p + 2'd1] = bus.fetch_error;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= 2'd0;
            head_pc  <= RESET_PC;
            exp_addr <= RESET_PC[31:2];
            skip     <= RESET_PC[1];
        end else if (flush) begin
            count    <= 2'd0;
            head_pc  <= {flush_pc[31:1], 1'b0};
            exp_addr <= flush_pc[31:2];
            skip     <= flush_pc[1];
        end else begin
            count   <= count_n;
            head_pc <= head_pc + (pop ? (is16 ? 32'd2 : 32'd4) : 32'd0);
            if (accept) begin
                exp_addr <= exp_addr + 30'd1;
                skip     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        hw <= hw_n;
        hf <= hf_n;
    end
endmodule

// File: tb/tb_rv_fetch_aligner.sv
// tb_rv_fetch_aligner: random fetch/flush/backpressure traffic checked against a program-order memory model
module tb_rv_fetch_aligner;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    rv_fetch_aligner_if bus();

    rv_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .flush_pc(flush_pc),
        .bus(bus.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory image: {fault, data} per word address, filled on first touch
    bit [32:0] mem [bit [29:0]];

    function automatic bit [32:0] word_at(input bit [29:0] a);
        bit [31:0] d;
        if (!mem.exists(a)) begin
            d = $urandom;
            if ($urandom_range(1) == 0) d[1:0] = 2'b11;
            if ($urandom_range(1) == 0) d[17:16] = 2'b11;
            mem[a] = {($urandom_range(15) == 0), d};
        end
        return mem[a];
    endfunction

    function automatic bit [16:0] half_at(input bit [31:0] a);
        bit [32:0] w;
        w = word_at(a[31:2]);
        return {w[32], a[1] ? w[31:16] : w[15:0]};
    endfunction

    // program-order model: next instruction PC and next word the fetch side offers
    bit [31:0] pc;
    bit [29:0] ptr;
    int        stale_n;

    task automatic model_reset();
        pc = 32'h0;
        ptr = 30'h0;
        stale_n = 0;
    endtask

    initial begin
        bit [31:0] d;
        bit [16:0] h0, h1;
        bit [29:0] a;
        bit [32:0] w;
        bit        is16, ev, er, fv, sv;
        int        occ;
        mem[30'h0] = {1'b0, 32'h0000_0013};
        bus.fetch_valid = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.fetch_data = 32'h0;
        bus.fetch_error = 1'b0;
        bus.inst_ready = 1'b0;
        model_reset();
        #12;
        check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (cyc == 2500) begin
                #2 reset_n = 1'b0;
                #1;
                check("midrst_inst_valid", 32'(bus.inst_valid), 32'h0);
                check("midrst_fetch_ready", 32'(bus.fetch_ready), 32'h0);
                @(negedge clock);
                reset_n = 1'b1;
                model_reset();
            end
            flush = $urandom_range(49) == 0;
            case ($urandom_range(3))
                0: flush_pc = {20'h0, 12'($urandom)};
                1: flush_pc = {28'hFFFF_FFF, 4'($urandom)};
                2: flush_pc = 32'h0000_0102;
                default: flush_pc = $urandom;
            endcase
            bus.inst_ready = (cyc % 400 < 60) ? 1'b0 : ($urandom_range(9) < 7);
            fv = $urandom_range(3) != 0 || stale_n > 0;
            sv = fv && (stale_n > 0 || $urandom_range(15) == 0);
            a = sv ? ptr ^ 30'h5 : ptr;
            w = word_at(a);
            bus.fetch_valid = fv;
            bus.fetch_addr = {a, 2'($urandom)};
            bus.fetch_data = w[31:0];
            bus.fetch_error = w[32];
            #1;
            d = {ptr, 2'b00} - pc;
            occ = d[31] ? 0 : int'(d >> 1);
            h0 = half_at(pc);
            h1 = half_at(pc + 32'd2);
            is16 = h0[1:0] != 2'b11 || h0[16];
            ev = !flush && occ >= 1 && (is16 || occ >= 2);
            er = !flush && (sv || occ <= 1);
            check("inst_valid", 32'(bus.inst_valid), 32'(ev));
            if (fv) check("fetch_ready", 32'(bus.fetch_ready), 32'(er));
            if (ev && bus.inst_valid) begin
                check("inst", bus.inst, is16 ? {16'h0, h0[15:0]} : {h1[15:0], h0[15:0]});
                check("inst_pc", bus.inst_pc, pc);
                check("inst_fault", 32'(bus.inst_fault), 32'(h0[16] || (!is16 && h1[16])));
            end
            if (flush) begin
                pc = {flush_pc[31:1], 1'b0};
                ptr = flush_pc[31:2];
                stale_n = $urandom_range(2);
            end else begin
                if (ev && bus.inst_ready) pc += is16 ? 32'd2 : 32'd4;
                if (fv && er) begin
                    if (sv) stale_n = stale_n > 0 ? stale_n - 1 : 0;
                    else ptr++;
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
